dpc_manual_bp_lut: RTL and testbench
====================================

Name: dpc_manual_bp_lut

Overview:
- Holds the manual bad-pixel coordinate table that software writes through the detector AXI4-Lite register block (LUT write/read port), and serves AXI readback of that table.
- Sits in the pixel stream directly ahead of the DPC detector: counts raster coordinates, compares each pixel against the next table entry, and forwards the pixel with a 1-bit manual-bad-pixel flag aligned to it.

Parameters:
- AXIS_TDATA_WIDTH, 24, pixel data width
- LUT_INDEX_WIDTH, 8, width of manual_bp_num and of the table pointer
- LUT_INDEX_NUM, 128, table depth in entries
- C_S_AXI_DATA_WIDTH, 32, LUT word width
- C_S_AXI_ADDR_WIDTH, 32, LUT address width
- LUT_BASE, 4, register index of table entry 0

Ports:
- clk  in  1  pixel/AXI clock (single clock domain)
- rst  in  1  synchronous, active-high reset
- go  in  1  manual table enable
- manual_bp_num  in  LUT_INDEX_WIDTH  valid entry count
- wen_lut  in  1  table write strobe, one cycle per word
- waddr_lut  in  C_S_AXI_ADDR_WIDTH  register index of write
- wdata_lut  in  C_S_AXI_DATA_WIDTH  entry: [31:16]=row y, [15:0]=col x
- raddr_lut  in  C_S_AXI_ADDR_WIDTH  register index of readback
- rdata_lut  out  C_S_AXI_DATA_WIDTH  readback data, combinational
- s_axis_tdata  in  AXIS_TDATA_WIDTH  input pixel
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tuser  in  1  start of frame
- s_axis_tlast  in  1  end of line
- m_axis_tdata  out  AXIS_TDATA_WIDTH
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tuser  out  1
- m_axis_tlast  out  1
- m_axis_manual_bp  out  1  pixel is listed in table

Behaviour:
- Table: LUT_INDEX_NUM x C_S_AXI_DATA_WIDTH RAM, not cleared by rst. Write when wen_lut and LUT_BASE <= waddr_lut < LUT_BASE+LUT_INDEX_NUM, at index waddr_lut-LUT_BASE. Writes outside that range are ignored.
- Readback: rdata_lut = table[raddr_lut-LUT_BASE], asynchronous, same cycle. The upstream slave samples rdata_lut in the cycle raddr_lut changes. Out-of-range raddr_lut returns 0.
- Entries are raster-sorted ascending (y major, x minor) and unique; software guarantees this.
- Stream: 1-deep register slice with latency 1. s_axis_tready = ~m_axis_tvalid | m_axis_tready. Data, tuser, tlast and flag are registered together on each accepted beat (beat = s_axis_tvalid & s_axis_tready).
- Coordinates: the beat with tuser=1 is (0,0). After that, x increments per beat. On a tlast beat, x is set to 0 and y increments. 16-bit counters that wrap.
- FSM, all transitions on accepted beats only:
  - IDLE: flag 0. A SOF beat latches go and min(manual_bp_num, LUT_INDEX_NUM) as num, clears ptr, and evaluates that beat. Next state is ACTIVE if go_l & num!=0, otherwise BYPASS.
  - ACTIVE: entry = table[ptr].
    - entry == coord: flag=1, ptr++.
    - entry raster-less than coord (stale): flag=0, ptr++.
    - Otherwise: flag=0, ptr holds.
    - When ptr reaches num, go to DONE.
  - DONE / BYPASS: flag 0 until the next SOF.
  - A SOF in any state restarts as in IDLE. A mid-frame SOF aborts the current frame.
- go and manual_bp_num changes take effect only at SOF. Table writes during ACTIVE take effect immediately; this is legal but the result is undefined for that frame.
- Reset: state IDLE, ptr 0, counters 0, m_axis_tvalid 0, m_axis_tdata/tuser/tlast/manual_bp 0. Reset mid-frame drops the beat held in the slice.
- Backpressure: while m_axis_tvalid & ~m_axis_tready, all outputs hold, and ptr and counters do not advance.

Optional Feature:
- DPC_MANUAL_BP_STATS_EN: adds output manual_bp_hits [LUT_INDEX_WIDTH-1:0]. It counts flag=1 beats in the current frame, saturates at all-ones, is copied to manual_bp_hits on the next SOF, and resets to 0.
- Without the macro: no port, no counter logic.

Test Plan:
- Write 3 entries (0,1),(2,5),(3,0) at waddr 4..6, num=3, go=1; send 8x4 frame -> flag=1 exactly on (1,0),(5,2),(0,3); FSM reaches DONE after (0,3).
- AXI readback: raddr_lut=5 after writing 0x00020005 at waddr 5 -> rdata_lut=0x00020005 in the same cycle; raddr_lut=200 -> 0.
- go=0 with valid table -> frame passes unchanged, flag never set; go raised mid-frame -> no flags until next SOF.
- Random m_axis_tready=0 stalls during the first test -> output data/flag sequence identical, no beat lost or duplicated.
- Stale entry (1,0) listed before (0,0)-region pixels are skipped via a mid-frame SOF restart -> next frame flags (1,0) correctly; num=200 clamps to 128.
- rst asserted mid-frame -> m_axis_tvalid=0 next cycle; subsequent SOF frame flags correctly, table contents preserved.

Source files
------------

// File: rtl/dpc_manual_bp_lut.sv
// dpc_manual_bp_lut
// Manual bad-pixel coordinate table written by software over the detector
// register port, plus a one-deep stream slice that tags every pixel whose
// raster coordinate appears in the table. The tag travels with the pixel.
//
// Build option: define DPC_MANUAL_BP_STATS_EN to add the manual_bp_hits
// output, the number of tagged pixels seen in the previous frame.
module dpc_manual_bp_lut #(
   parameter int AXIS_TDATA_WIDTH   = 24,
   parameter int LUT_INDEX_WIDTH    = 8,
   parameter int LUT_INDEX_NUM      = 128,
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int LUT_BASE           = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          go,
   input  logic [LUT_INDEX_WIDTH-1:0]    manual_bp_num,
   input  logic                          wen_lut,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] waddr_lut,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_lut,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] raddr_lut,
   output logic [C_S_AXI_DATA_WIDTH-1:0] rdata_lut,
   input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic                          s_axis_tuser,
   input  logic                          s_axis_tlast,
   output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tuser,
   output logic                          m_axis_tlast,
   output logic                          m_axis_manual_bp
`ifdef DPC_MANUAL_BP_STATS_EN
   ,
   output logic [LUT_INDEX_WIDTH-1:0]    manual_bp_hits
`endif
);

   localparam int IDX_W = $clog2(LUT_INDEX_NUM);
   localparam logic [LUT_INDEX_WIDTH-1:0]    NUM_MAX    = LUT_INDEX_WIDTH'(LUT_INDEX_NUM);
   localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_BASE  = C_S_AXI_ADDR_WIDTH'(LUT_BASE);
   localparam logic [C_S_AXI_ADDR_WIDTH-1:0] ADDR_DEPTH = C_S_AXI_ADDR_WIDTH'(LUT_INDEX_NUM);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_DONE,
      ST_BYPASS
   } state_t;

   // Coordinate table; deliberately has no reset so software contents survive rst
   logic [C_S_AXI_DATA_WIDTH-1:0] r_lut [LUT_INDEX_NUM];

   state_t                     r_state;
   logic [LUT_INDEX_WIDTH-1:0] r_ptr;
   logic [LUT_INDEX_WIDTH-1:0] r_num;
   logic [15:0]                r_x;
   logic [15:0]                r_y;

   logic [C_S_AXI_ADDR_WIDTH-1:0] w_wOff;
   logic [C_S_AXI_ADDR_WIDTH-1:0] w_rOff;
   logic                          w_beat;
   logic [15:0]                   w_curX;
   logic [15:0]                   w_curY;
   logic [31:0]                   w_coordKey;
   logic [LUT_INDEX_WIDTH-1:0]    w_numClamp;
   logic                          w_evalActive;
   logic [LUT_INDEX_WIDTH-1:0]    w_evalPtr;
   logic [LUT_INDEX_WIDTH-1:0]    w_evalNum;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_entry;
   logic                          w_hit;
   logic                          w_stale;
   logic [LUT_INDEX_WIDTH-1:0]    w_ptrNext;
   state_t                        w_stateNext;

   // An address below LUT_BASE wraps to a huge offset, so one unsigned
   // compare against the depth rejects both out-of-range directions.
   assign w_wOff = waddr_lut - ADDR_BASE;
   assign w_rOff = raddr_lut - ADDR_BASE;

   // Software writes land in the table immediately, even mid-frame
   always_ff @(posedge clk) begin
      if (wen_lut && (w_wOff < ADDR_DEPTH)) begin
         r_lut[w_wOff[IDX_W-1:0]] <= wdata_lut;
      end
   end

   // Readback is combinational because the register block samples it in the same cycle
   always_comb begin
      rdata_lut = '0;
      if (w_rOff < ADDR_DEPTH) begin
         rdata_lut = r_lut[w_rOff[IDX_W-1:0]];
      end
   end

   // The slice accepts whenever its single stage is empty or draining this cycle
   assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
   assign w_beat        = s_axis_tvalid & s_axis_tready;

   // Work out this beat's coordinate and whether it matches the next table entry.
   // A start-of-frame beat is evaluated as if the frame state had just been
   // restarted: coordinate (0,0), pointer 0, fresh go and clamped count.
   always_comb begin
      w_curX       = r_x;
      w_curY       = r_y;
      w_evalPtr    = r_ptr;
      w_evalNum    = r_num;
      w_evalActive = (r_state == ST_ACTIVE);
      w_numClamp   = (manual_bp_num > NUM_MAX) ? NUM_MAX : manual_bp_num;
      if (s_axis_tuser) begin
         w_curX       = '0;
         w_curY       = '0;
         w_evalPtr    = '0;
         w_evalNum    = w_numClamp;
         w_evalActive = go && (w_numClamp != '0);
      end

      // Row in the upper half, column in the lower half: an unsigned compare
      // of the packed word is exactly raster order.
      w_coordKey = {w_curY, w_curX};
      w_entry    = r_lut[w_evalPtr[IDX_W-1:0]];
      w_hit      = w_evalActive && (w_entry == w_coordKey);
      w_stale    = w_evalActive && (w_entry < w_coordKey);

      w_ptrNext = w_evalPtr;
      if (w_hit || w_stale) begin
         w_ptrNext = w_evalPtr + LUT_INDEX_WIDTH'(1);
      end

      w_stateNext = r_state;
      if (w_evalActive) begin
         w_stateNext = (w_ptrNext == w_evalNum) ? ST_DONE : ST_ACTIVE;
      end else if (s_axis_tuser) begin
         w_stateNext = ST_BYPASS;
      end
   end

   // Frame FSM, raster counters and output stage all advance only on accepted
   // beats, so a stalled output freezes everything together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= ST_IDLE;
         r_ptr            <= '0;
         r_num            <= '0;
         r_x              <= '0;
         r_y              <= '0;
         m_axis_tvalid    <= 1'b0;
         m_axis_tdata     <= '0;
         m_axis_tuser     <= 1'b0;
         m_axis_tlast     <= 1'b0;
         m_axis_manual_bp <= 1'b0;
      end else if (w_beat) begin
         m_axis_tvalid    <= 1'b1;
         m_axis_tdata     <= s_axis_tdata;
         m_axis_tuser     <= s_axis_tuser;
         m_axis_tlast     <= s_axis_tlast;
         m_axis_manual_bp <= w_hit;

         if (s_axis_tlast) begin
            r_x <= '0;
            r_y <= w_curY + 16'd1;
         end else begin
            r_x <= w_curX + 16'd1;
            r_y <= w_curY;
         end

         if (s_axis_tuser) begin
            r_num <= w_numClamp;
         end
         r_ptr   <= w_ptrNext;
         r_state <= w_stateNext;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

`ifdef DPC_MANUAL_BP_STATS_EN
   logic [LUT_INDEX_WIDTH-1:0] r_hitCount;

   // Saturating per-frame hit tally, published and restarted at each start of frame
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hitCount     <= '0;
         manual_bp_hits <= '0;
      end else if (w_beat) begin
         if (s_axis_tuser) begin
            manual_bp_hits <= r_hitCount;
            r_hitCount     <= LUT_INDEX_WIDTH'(w_hit);
         end else if (w_hit && (r_hitCount != '1)) begin
            r_hitCount <= r_hitCount + LUT_INDEX_WIDTH'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_dpc_manual_bp_lut.sv
// Testbench for dpc_manual_bp_lut: randomized stalls and pixel data, checked
// against a queue-based reference model of the manual bad-pixel tagging.
module tb_dpc_manual_bp_lut;

   localparam int DW   = 24;
   localparam int IW   = 8;
   localparam int NUM  = 128;
   localparam int AW   = 32;
   localparam int LW   = 32;
   localparam int BASE = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          user;
      logic          last;
      logic          flag;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          go;
   logic [IW-1:0] manual_bp_num;
   logic          wen_lut;
   logic [AW-1:0] waddr_lut;
   logic [LW-1:0] wdata_lut;
   logic [AW-1:0] raddr_lut;
   logic [LW-1:0] rdata_lut;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic          s_axis_tuser;
   logic          s_axis_tlast;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tuser;
   logic          m_axis_tlast;
   logic          m_axis_manual_bp;

   int nChecks = 0;
   int nFails  = 0;
   int beatsSeen = 0;
   int flagsSeen = 0;

   // Reference model state
   logic [31:0] tbLut [NUM];
   int unsigned pendKeys[$];
   int unsigned modelX = 0;
   int unsigned modelY = 0;
   logic        mValidModel = 1'b0;
   beat_t       expQ[$];

   always #5 clk = ~clk;

   dpc_manual_bp_lut #(
      .AXIS_TDATA_WIDTH(DW),
      .LUT_INDEX_WIDTH(IW),
      .LUT_INDEX_NUM(NUM),
      .C_S_AXI_DATA_WIDTH(LW),
      .C_S_AXI_ADDR_WIDTH(AW),
      .LUT_BASE(BASE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .go(go),
      .manual_bp_num(manual_bp_num),
      .wen_lut(wen_lut),
      .waddr_lut(waddr_lut),
      .wdata_lut(wdata_lut),
      .raddr_lut(raddr_lut),
      .rdata_lut(rdata_lut),
      .s_axis_tdata(s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tuser(s_axis_tuser),
      .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tuser(m_axis_tuser),
      .m_axis_tlast(m_axis_tlast),
      .m_axis_manual_bp(m_axis_manual_bp)
   );

   // Hard stop in case the bench itself gets stuck
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] lutModel(input int unsigned addr);
      if (addr >= BASE && addr < BASE + NUM) return tbLut[addr - BASE];
      return 32'h0;
   endfunction

   task automatic modelReset();
      pendKeys.delete();
      expQ.delete();
      modelX = 0;
      modelY = 0;
      mValidModel = 1'b0;
   endtask

   // Tagging rules: at SOF load the first min(num,NUM) table keys when go is set;
   // each beat compares against the oldest pending key, dropping it on match or
   // when it is already behind the current raster position.
   task automatic modelBeat(input logic [DW-1:0] d, input logic u, input logic l, output beat_t b);
      int unsigned key;
      int unsigned lim;
      if (u) begin
         modelX = 0;
         modelY = 0;
         pendKeys.delete();
         if (go) begin
            lim = (int'(manual_bp_num) > NUM) ? NUM : int'(manual_bp_num);
            for (int i = 0; i < int'(lim); i++) pendKeys.push_back(tbLut[i]);
         end
      end
      key = modelY * 65536 + modelX;
      b.data = d;
      b.user = u;
      b.last = l;
      b.flag = 1'b0;
      if (pendKeys.size() > 0) begin
         if (pendKeys[0] == key) begin
            b.flag = 1'b1;
            void'(pendKeys.pop_front());
         end else if (pendKeys[0] < key) begin
            void'(pendKeys.pop_front());
         end
      end
      if (l) begin
         modelX = 0;
         modelY = (modelY + 1) % 65536;
      end else begin
         modelX = (modelX + 1) % 65536;
      end
   endtask

   // One clock cycle: drive at the falling edge, check outputs 1 unit later
   task automatic stepCycle(input logic inValid, input logic [DW-1:0] inData, input logic inUser,
                            input logic inLast, input logic outReady, output logic accepted);
      beat_t expBeat;
      beat_t newBeat;
      s_axis_tvalid = inValid;
      s_axis_tdata  = inData;
      s_axis_tuser  = inUser;
      s_axis_tlast  = inLast;
      m_axis_tready = outReady;
      #1;
      checkOutput("mValid", 64'(m_axis_tvalid), 64'(mValidModel));
      checkOutput("sReady", 64'(s_axis_tready), 64'(!mValidModel || outReady));
      if (mValidModel && outReady && expQ.size() > 0) begin
         expBeat = expQ.pop_front();
         checkOutput("outData", 64'({m_axis_tdata, m_axis_tuser, m_axis_tlast}),
                     64'({expBeat.data, expBeat.user, expBeat.last}));
         checkOutput("outFlag", 64'(m_axis_manual_bp), 64'(expBeat.flag));
         beatsSeen++;
         flagsSeen += int'(m_axis_manual_bp);
      end
      accepted = inValid && (!mValidModel || outReady);
      if (accepted) begin
         modelBeat(inData, inUser, inLast, newBeat);
         expQ.push_back(newBeat);
      end
      mValidModel = accepted ? 1'b1 : (outReady ? 1'b0 : mValidModel);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Send a w x h raster frame (or its first stopAfter beats) with random stalls
   task automatic applyStimulus(input int w, input int h, input int stallPct, input int goRaiseAt, input int stopAfter);
      logic acc;
      int tries;
      int total;
      logic [DW-1:0] d;
      total = w * h;
      if (stopAfter >= 0 && stopAfter < total) total = stopAfter;
      for (int k = 0; k < total; k++) begin
         d = DW'($urandom);
         if (k == goRaiseAt) go = 1'b1;
         if (stallPct > 0 && $urandom_range(99) < stallPct)
            stepCycle(1'b0, DW'($urandom), 1'b0, 1'b0, $urandom_range(99) >= stallPct, acc);
         acc = 1'b0;
         tries = 0;
         while (!acc && tries < 64) begin
            stepCycle(1'b1, d, k == 0, (k % w) == w - 1,
                      (stallPct == 0) || ($urandom_range(99) >= stallPct), acc);
            tries++;
         end
         if (!acc) checkOutput("beatAcceptTimeout", 64'(tries), 64'(0));
      end
   endtask

   task automatic drain();
      logic acc;
      int n;
      n = 0;
      while ((expQ.size() > 0 || mValidModel) && n < 20) begin
         stepCycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
         n++;
      end
      checkOutput("drainEmpty", 64'(expQ.size()), 64'(0));
   endtask

   task automatic writeLut(input int unsigned addr, input logic [31:0] data);
      wen_lut   = 1'b1;
      waddr_lut = AW'(addr);
      wdata_lut = data;
      @(posedge clk);
      @(negedge clk);
      wen_lut = 1'b0;
      if (addr >= BASE && addr < BASE + NUM) tbLut[addr - BASE] = data;
   endtask

   task automatic checkRead(input int unsigned addr);
      raddr_lut = AW'(addr);
      #1;
      checkOutput($sformatf("readback@%0d", addr), 64'(rdata_lut), 64'(lutModel(addr)));
   endtask

   task automatic checkFrameCounts(input string tag, input int f0, input int b0, input int expFlags, input int expBeats);
      checkOutput({tag, "Flags"}, 64'(flagsSeen - f0), 64'(expFlags));
      if (expBeats >= 0) checkOutput({tag, "Beats"}, 64'(beatsSeen - b0), 64'(expBeats));
   endtask

   initial begin
      int f0;
      int b0;
      int unsigned p;
      logic acc;
      rst = 1'b1;
      go = 1'b0;
      manual_bp_num = '0;
      wen_lut = 1'b0;
      waddr_lut = '0;
      wdata_lut = '0;
      raddr_lut = '0;
      s_axis_tdata = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tuser = 1'b0;
      s_axis_tlast = 1'b0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < NUM; i++) tbLut[i] = 32'h0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("rstValid", 64'(m_axis_tvalid), 64'(0));
      checkOutput("rstData", 64'(m_axis_tdata), 64'(0));
      checkOutput("rstUser", 64'(m_axis_tuser), 64'(0));
      checkOutput("rstLast", 64'(m_axis_tlast), 64'(0));
      checkOutput("rstFlag", 64'(m_axis_manual_bp), 64'(0));
      rst = 1'b0;
      modelReset();

      $display("[TB] table write and readback");
      writeLut(4, 32'h0000_0001);
      writeLut(5, 32'h0002_0005);
      writeLut(6, 32'h0003_0000);
      writeLut(131, 32'hCAFE_0077);
      writeLut(132, 32'hDEAD_0001);
      writeLut(3, 32'hDEAD_0002);
      checkRead(5);
      checkRead(200);
      checkRead(4);
      checkRead(131);
      checkRead(3);
      checkRead(132);

      $display("[TB] three-entry frame with random stalls");
      go = 1'b1;
      manual_bp_num = 8'd3;
      f0 = flagsSeen; b0 = beatsSeen;
      applyStimulus(8, 4, 35, -1, -1);
      drain();
      checkFrameCounts("stallFrame", f0, b0, 3, 32);

      $display("[TB] same frame without stalls");
      f0 = flagsSeen; b0 = beatsSeen;
      applyStimulus(8, 4, 0, -1, -1);
      drain();
      checkFrameCounts("plainFrame", f0, b0, 3, 32);

      $display("[TB] go low, then go raised mid-frame");
      go = 1'b0;
      f0 = flagsSeen; b0 = beatsSeen;
      applyStimulus(8, 4, 20, -1, -1);
      applyStimulus(8, 4, 0, 10, -1);
      drain();
      checkFrameCounts("goOff", f0, b0, 0, 64);
      f0 = flagsSeen; b0 = beatsSeen;
      applyStimulus(8, 4, 20, -1, -1);
      drain();
      checkFrameCounts("goOnNext", f0, b0, 3, 32);

      $display("[TB] mid-frame SOF restart");
      f0 = flagsSeen; b0 = beatsSeen;
      applyStimulus(8, 4, 20, -1, 5);
      applyStimulus(8, 4, 20, -1, -1);
      drain();
      checkFrameCounts("restart", f0, b0, 4, 37);

      $display("[TB] full table, stale entry, count clamp");
      writeLut(BASE + 0, 32'h0000_0001);
      writeLut(BASE + 1, 32'h0000_0014);
      for (int i = 2; i < NUM; i++) begin
         p = 8 + i;
         writeLut(BASE + i, {16'(p / 8), 16'(p % 8)});
      end
      checkRead(BASE + 1);
      checkRead(BASE + NUM - 1);
      manual_bp_num = 8'd200;
      go = 1'b1;
      f0 = flagsSeen; b0 = beatsSeen;
      applyStimulus(8, 20, 30, -1, -1);
      drain();
      checkFrameCounts("clampFrame", f0, b0, 127, 160);

      $display("[TB] reset mid-frame");
      applyStimulus(8, 20, 0, -1, 10);
      stepCycle(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
      rst = 1'b1;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("validAfterReset", 64'(m_axis_tvalid), 64'(0));
      rst = 1'b0;
      modelReset();
      f0 = flagsSeen; b0 = beatsSeen;
      applyStimulus(8, 20, 25, -1, -1);
      drain();
      checkFrameCounts("afterReset", f0, b0, 127, 160);
      checkRead(BASE);
      checkRead(BASE + NUM - 1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
